// File: rtl/bram_grp_pkg.sv
// Shared types and constants for the BRAM line-buffer group write side.
// Everything here is imported by bram_group_wr_ctrl and pix_packer.
package bram_grp_pkg;

    localparam int DEF_PIX_W        = 8;
    localparam int DEF_PIX_PER_WORD = 8;
    localparam int DEF_NUM_BRAM     = 3;
    localparam int WORD_W           = DEF_PIX_W * DEF_PIX_PER_WORD;
    // Group write-address counters are this wide and wrap on purpose.
    localparam int ADDR_W           = 9;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN
    } state_t;

    function automatic logic [7:0] onehot_sel(input logic [1:0] line_sel);
        return 8'd1 << line_sel;
    endfunction

endpackage

// File: rtl/bram_group_wr_ctrl_pix_packer.sv
// Packs pixels into one BRAM word and flags when the word must be written.
// Macro EOL_PAD_EN: pad a short end-of-line word with its last pixel, full mask.
module pix_packer
    import bram_grp_pkg::*;
#(
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          accept,
    input  logic                          eol,
    input  logic [PIX_W-1:0]              data,
    output logic                          word_ready,
    output logic [PIX_W*PIX_PER_WORD-1:0] word,
    output logic [PIX_PER_WORD-1:0]       mask
);

    localparam int WW    = PIX_W * PIX_PER_WORD;
    localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [IDX_W-1:0]        idx;
    logic [WW-1:0]           word_q;
    logic [PIX_PER_WORD-1:0] mask_q;
    logic [WW-1:0]           merged_word;
    logic [PIX_PER_WORD-1:0] merged_mask;

    // The outgoing word already includes the pixel arriving this cycle.
    always_comb begin
        merged_word = word_q;
        merged_mask = mask_q;
        merged_word[idx*PIX_W +: PIX_W] = data;
        merged_mask[idx] = 1'b1;
        word = merged_word;
        mask = merged_mask;
`ifdef EOL_PAD_EN
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (k > int'(idx)) begin
                word[k*PIX_W +: PIX_W] = data;
            end
        end
        mask = '1;
`endif
    end

    assign word_ready = accept && ((idx == IDX_W'(PIX_PER_WORD - 1)) || eol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            word_q <= '0;
            mask_q <= '0;
        end else if (clear) begin
            idx    <= '0;
            word_q <= '0;
            mask_q <= '0;
        end else if (accept) begin
            if (word_ready) begin
                idx    <= '0;
                word_q <= '0;
                mask_q <= '0;
            end else begin
                idx    <= idx + 1'b1;
                word_q <= merged_word;
                mask_q <= merged_mask;
            end
        end
    end

endmodule

// File: rtl/bram_group_wr_ctrl.sv
// Write-side controller for the three-BRAM line-buffer group: frame FSM, line
// rotation and registered write strobes. Optional macro EOL_PAD_EN (see pix_packer).
module bram_group_wr_ctrl
    import bram_grp_pkg::*;
#(
    parameter int PIX_W        = DEF_PIX_W,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int NUM_BRAM     = DEF_NUM_BRAM,
    parameter int LW_W         = 12
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   frame_start,
    input  logic [LW_W-1:0]                        cfg_line_width,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PIX_W-1:0]                       in_data,
    output logic [PIX_W*PIX_PER_WORD*NUM_BRAM-1:0] wr_data,
    output logic [PIX_PER_WORD*NUM_BRAM-1:0]       wr_data_mask,
    output logic                                   wr_data_group_en,
    output logic [NUM_BRAM-1:0]                    wr_addr_inc,
    output logic                                   wr_addr_reset,
    output logic                                   line_done,
    output logic [1:0]                             line_bram,
    output logic [15:0]                            line_cnt,
    output logic                                   frame_abort
);

    localparam int WW = PIX_W * PIX_PER_WORD;

    state_t                  state;
    logic [LW_W-1:0]         lw_q;
    logic [LW_W-1:0]         pix_cnt;
    logic [1:0]              line_sel;
    logic                    accept;
    logic                    eol;
    logic                    word_ready;
    logic [WW-1:0]           word;
    logic [PIX_PER_WORD-1:0] mask;

    // A new frame request always beats a pixel offered in the same cycle.
    assign in_ready = (state == RUN) && !frame_start && (lw_q != '0);
    assign accept   = in_valid && in_ready;
    assign eol      = (pix_cnt == lw_q - LW_W'(1));

    pix_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == CLR),
        .accept     (accept),
        .eol        (eol),
        .data       (in_data),
        .word_ready (word_ready),
        .word       (word),
        .mask       (mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lw_q             <= '0;
            pix_cnt          <= '0;
            line_sel         <= '0;
            wr_data          <= '0;
            wr_data_mask     <= '0;
            wr_data_group_en <= 1'b0;
            wr_addr_inc      <= '0;
            wr_addr_reset    <= 1'b0;
            line_done        <= 1'b0;
            line_bram        <= '0;
            line_cnt         <= '0;
            frame_abort      <= 1'b0;
        end else begin
            wr_data          <= '0;
            wr_data_mask     <= '0;
            wr_data_group_en <= 1'b0;
            wr_addr_inc      <= '0;
            wr_addr_reset    <= 1'b0;
            line_done        <= 1'b0;
            frame_abort      <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= CLR;
                    end
                end
                CLR: begin
                    lw_q          <= cfg_line_width;
                    pix_cnt       <= '0;
                    line_sel      <= '0;
                    line_cnt      <= '0;
                    wr_addr_reset <= 1'b1;
                    state         <= RUN;
                end
                RUN: begin
                    if (frame_start) begin
                        state <= CLR;
                        if (pix_cnt != '0) begin
                            frame_abort <= 1'b1;
                        end
                    end else if (accept) begin
                        pix_cnt <= eol ? '0 : pix_cnt + LW_W'(1);
                        if (word_ready) begin
                            wr_data_group_en <= 1'b1;
                            wr_addr_inc      <= NUM_BRAM'(onehot_sel(line_sel));
                            for (int b = 0; b < NUM_BRAM; b++) begin
                                if (line_sel == 2'(b)) begin
                                    wr_data[b*WW +: WW] <= word;
                                    wr_data_mask[b*PIX_PER_WORD +: PIX_PER_WORD] <= mask;
                                end
                            end
                        end
                        // Lines rotate round-robin; addresses keep running per BRAM.
                        if (eol) begin
                            line_done <= 1'b1;
                            line_bram <= line_sel;
                            if (line_cnt != 16'hFFFF) begin
                                line_cnt <= line_cnt + 16'd1;
                            end
                            line_sel <= (line_sel == 2'(NUM_BRAM - 1)) ? 2'd0 : line_sel + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bram_group_wr_ctrl.md
Name: bram_group_wr_ctrl

Overview:
Write-side controller feeding the three-BRAM line-buffer group of the sliding-window engine. Accepts an 8-bit pixel stream and packs 8 pixels into each 64-bit word. Rotates image lines across BRAM 0/1/2 and drives the group's write data, byte mask, write enable, per-BRAM address increment and address reset. Emits line-completion status for the downstream window reader.

Parameters:
PIX_W, 8, pixel width in bits
PIX_PER_WORD, 8, pixels per BRAM word (one mask bit per pixel)
NUM_BRAM, 3, BRAMs in the group; lines rotate across them
LW_W, 12, width of the line-width config (max 4095 pixels/line)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse; clears addresses and starts a frame
cfg_line_width  in  LW_W  pixels per line; sampled in CLR; 0 = hold stalled
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  PIX_W  pixel
wr_data  out  PIX_W*PIX_PER_WORD*NUM_BRAM  packed word, placed in the active BRAM's slice
wr_data_mask  out  PIX_PER_WORD*NUM_BRAM  byte mask, active slice only
wr_data_group_en  out  1  write strobe
wr_addr_inc  out  NUM_BRAM  one-hot address increment, coincident with the strobe
wr_addr_reset  out  1  clears all group write addresses
line_done  out  1  pulse when the last word of a line is written
line_bram  out  2  BRAM index holding the completed line (valid with line_done)
line_cnt  out  16  lines completed in the current frame
frame_abort  out  1  pulse when frame_start truncates a partial line

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs 0: in_ready, wr_data, wr_data_mask, wr_data_group_en, wr_addr_inc, wr_addr_reset, line_done, line_bram, line_cnt, frame_abort.
- FSM states:
  - IDLE -> CLR on frame_start.
  - CLR (1 cycle): registered wr_addr_reset=1 next cycle; latch cfg_line_width; clear pixel cnt, byte idx, line_sel=0, line_cnt=0; -> RUN.
  - RUN -> CLR on frame_start.
- in_ready = (state==RUN) && !frame_start && (lw_q!=0). frame_start wins over a simultaneous beat; that beat is not accepted.
- Packing: accepted pixel k of a word goes into byte k (byte 0 = LSBs) of the word buffer; mask bit k is set.
- Word emit: on the beat that fills byte 7, or on the beat that is pixel lw_q-1 of the line:
  - Next cycle, one-cycle pulse wr_data_group_en=1 and wr_addr_inc[line_sel]=1.
  - wr_data and wr_data_mask carry the buffer in slice line_sel; the other slices are 0.
- Throughput: 1 pixel/cycle, no stall. Buffer clears on emit; the next beat may be accepted in the same cycle as the emit pulse.
- End of line, registered with the last word's strobe:
  - line_done=1, line_bram=line_sel, line_cnt+1 (saturates at 0xFFFF).
  - line_sel advances 0->1->2->0.
- Addresses are never reset per line. Lines pack contiguously per BRAM, and the group's 9-bit counters wrap mod 512 by design.
- frame_start in RUN with pixel cnt!=0: partial buffer discarded, no write, frame_abort pulse next cycle, -> CLR.
- rst_n asserted mid-line: immediate return to IDLE; no write issued.

Optional Feature:
Macro EOL_PAD_EN.
- Defined: a partial end-of-line word fills unused bytes with the last valid pixel, and the mask is all ones.
- Undefined: unused bytes are 0 and the mask covers only the valid bytes.

Decomposition:
- Package bram_grp_pkg holds:
  - localparams WORD_W = PIX_W*PIX_PER_WORD and ADDR_W = 9
  - FSM state enum {IDLE, CLR, RUN}
  - function onehot_sel(line_sel)
- Sub-module pix_packer: byte index, buffer, mask, pad logic, word-ready flag.
- Top level keeps the FSM, line rotation and output registers.

Test Plan:
- Reset, then frame_start, lw=16, pixels 0x00..0x0F continuous -> wr_addr_reset pulse after CLR. Two strobes with wr_addr_inc=3'b001, wr_data[63:0]=0x0706050403020100 then 0x0F0E..08, mask 8'hFF. line_done with line_bram=0, line_cnt=1.
- lw=10, three lines -> per line: one full word plus a partial word with mask 8'h03 (bytes 0x09,0x08 in the low 2 bytes). wr_addr_inc 001, 010, 100 in turn. line_bram 0,1,2. With EOL_PAD_EN: upper 6 bytes are 0x09 and mask 8'hFF.
- frame_start after 5 pixels of a line -> no strobe, frame_abort=1, wr_addr_reset next cycle, line_sel back to 0.
- frame_start coincident with in_valid -> in_ready=0 that cycle, beat not consumed.
- cfg_line_width=0 at CLR -> in_ready stays 0, no strobes.
- rst_n dropped while byte idx=3 -> all outputs 0 asynchronously. After release and frame_start, the first word contains only new pixels.
